// File: rtl/miriscv_lsu_mc.sv
// Multi-cycle load/store unit: splits misaligned accesses into two word-aligned bus beats.
// Latency accept+3 cycles when aligned; the core is stalled via lsu_busy_o until the bus grants and acks.
module miriscv_lsu_mc #(
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [31:0]       lsu_data_i,
    input  logic              lsu_req_i,
    output logic              lsu_busy_o,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_err_o,
    output logic              mem_req_mo,
    output logic              mem_we_mo,
    output logic [3:0]        mem_mask_mo,
    output logic [ADDR_W-1:0] mem_addr_mo,
    output logic [31:0]       mem_data_mo,
    input  logic              mem_gnt_mi,
    input  logic              mem_rvalid_mi,
    input  logic [31:0]       mem_data_mi
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rej_q, rej_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic [31:0]       ldata_q, ldata_d;

    logic              in_legal;
    logic              in_misaligned;
    logic              in_reject;
    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [7:0]        en8;
    logic [31:0]       wrep;
    logic [63:0]       wdat64;
    logic              need2;
    logic [ADDR_W-1:0] addr_lo;
    logic [ADDR_W-1:0] addr_hi;
    logic [63:0]       rd64;
    logic [31:0]       rshift;
    logic [31:0]       rext;

    always_comb begin
        in_legal      = (lsu_size_i == 3'd0) || (lsu_size_i == 3'd1) || (lsu_size_i == 3'd2) ||
                        (lsu_size_i == 3'd4) || (lsu_size_i == 3'd5);
        in_misaligned = ((lsu_size_i[1:0] == 2'd1) && (lsu_addr_i[1:0] == 2'd3)) ||
                        ((lsu_size_i[1:0] == 2'd2) && (lsu_addr_i[1:0] != 2'd0));
        in_reject     = !in_legal || (in_misaligned && (MISALIGN_EN == 0));
    end

    // Byte lanes and store data are laid out over a 64-bit window spanning both words.
    always_comb begin
        off = addr_q[1:0];
        case (size_q[1:0])
            2'd0:    size_mask = 4'h1;
            2'd1:    size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
        case (size_q[1:0])
            2'd0:    wrep = {4{wdata_q[7:0]}};
            2'd1:    wrep = {2{wdata_q[15:0]}};
            default: wrep = wdata_q;
        endcase
        en8     = {4'h0, size_mask} << off;
        wdat64  = {32'h0, wrep} << {off, 3'b000};
        need2   = |en8[7:4];
        addr_lo = {addr_q[ADDR_W-1:2], 2'b00};
        addr_hi = addr_lo + ADDR_W'(4);
    end

    always_comb begin
        rd64   = (state_q == WAIT2) ? {mem_data_mi, rdata1_q} : {32'h0, mem_data_mi};
        rshift = 32'(rd64 >> {off, 3'b000});
        case (size_q)
            3'd0:    rext = {{24{rshift[7]}}, rshift[7:0]};
            3'd1:    rext = {{16{rshift[15]}}, rshift[15:0]};
            3'd4:    rext = {24'h0, rshift[7:0]};
            3'd5:    rext = {16'h0, rshift[15:0]};
            default: rext = rshift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rej_d       = rej_q;
        rdata1_d    = rdata1_q;
        ldata_d     = ldata_q;
        lsu_busy_o  = 1'b0;
        mem_req_mo  = 1'b0;
        mem_we_mo   = 1'b0;
        mem_mask_mo = 4'h0;
        mem_addr_mo = '0;
        mem_data_mo = 32'h0;
        case (state_q)
            IDLE: begin
                lsu_busy_o = lsu_req_i;
                if (lsu_req_i) begin
                    addr_d  = lsu_addr_i;
                    we_d    = lsu_we_i;
                    size_d  = lsu_size_i;
                    wdata_d = lsu_data_i;
                    rej_d   = in_reject;
                    state_d = in_reject ? DONE : REQ1;
                end
            end
            REQ1: begin
                lsu_busy_o  = 1'b1;
                mem_req_mo  = 1'b1;
                mem_we_mo   = we_q;
                mem_mask_mo = en8[3:0];
                mem_addr_mo = addr_lo;
                mem_data_mo = we_q ? wdat64[31:0] : 32'h0;
                if (mem_gnt_mi) state_d = WAIT1;
            end
            WAIT1: begin
                lsu_busy_o = 1'b1;
                if (mem_rvalid_mi) begin
                    if (need2) begin
                        rdata1_d = mem_data_mi;
                        state_d  = REQ2;
                    end else begin
                        if (!we_q) ldata_d = rext;
                        state_d = DONE;
                    end
                end
            end
            REQ2: begin
                lsu_busy_o  = 1'b1;
                mem_req_mo  = 1'b1;
                mem_we_mo   = we_q;
                mem_mask_mo = en8[7:4];
                mem_addr_mo = addr_hi;
                mem_data_mo = we_q ? wdat64[63:32] : 32'h0;
                if (mem_gnt_mi) state_d = WAIT2;
            end
            WAIT2: begin
                lsu_busy_o = 1'b1;
                if (mem_rvalid_mi) begin
                    if (!we_q) ldata_d = rext;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 3'd0;
            wdata_q  <= 32'h0;
            rej_q    <= 1'b0;
            rdata1_q <= 32'h0;
            ldata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            rej_q    <= rej_d;
            rdata1_q <= rdata1_d;
            ldata_q  <= ldata_d;
        end
    end

    assign lsu_data_o = ldata_q;
    assign lsu_err_o  = (state_q == DONE) && rej_q;

endmodule
